// File: rtl/skip_mem_pkg.sv
// Shared definitions for the skip-connection buffer read path.
// Contents: lane width, sequencer state encoding, lane slicing and clamp helpers.
package skip_mem_pkg;

   localparam int unsigned LANE_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Bit offset of lane 'lane' inside a packed memory word.
   function automatic int unsigned lane_lsb(input int unsigned lane);
      return lane * LANE_W;
   endfunction

   // Signed clamp at zero: negative lanes become 0, others unchanged.
   function automatic logic [LANE_W-1:0] relu_lane(input logic [LANE_W-1:0] v);
      return v[LANE_W-1] ? '0 : v;
   endfunction

endpackage

// File: rtl/skip_rd_fifo.sv
// Synchronous FIFO buffering words read from the skip memory.
// Ports: clk, rst (sync, active high), push/push_data, pop/pop_data (head word),
//        count (occupancy), empty, full.
// Caller guarantees no push when full and no pop when empty.
module skip_rd_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             pop_data,
   output logic [$clog2(DEPTH):0]       count,
   output logic                         empty,
   output logic                         full
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Pointer and occupancy tracking; depth is a power of two so pointers wrap freely.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign pop_data = mem[rd_ptr];
   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/skip_mem_reader.sv
// Read-side sequencer for the banked skip-connection buffer.
// Issues num_words consecutive reads from base_addr, absorbs the BRAM read
// latency with a tag line, buffers words in a FIFO and streams them out on a
// valid/ready handshake.
// Ports: clk, rst (sync, active high); start/base_addr/num_words command;
//        busy, done status; BRAM2_addr/BRAM2_wr/BRAM2_out memory side;
//        out_data/out_valid/out_ready residual-adder side.
// Build option: define SKIP_RELU_EN to clamp negative lanes to zero at the output.
module skip_mem_reader
   import skip_mem_pkg::*;
#(
   parameter int unsigned N_adder_tree = 16,
   parameter int unsigned addr_width   = 10,
   parameter int unsigned RD_LAT       = 1,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [addr_width-1:0]            base_addr,
   input  logic [addr_width:0]              num_words,
   output logic                             busy,
   output logic                             done,
   output logic [addr_width-1:0]            BRAM2_addr,
   output logic                             BRAM2_wr,
   input  logic [N_adder_tree*LANE_W-1:0]   BRAM2_out,
   output logic [N_adder_tree*LANE_W-1:0]   out_data,
   output logic                             out_valid,
   input  logic                             out_ready
);

   localparam int unsigned DATA_W = N_adder_tree * LANE_W;
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned SUM_W  = CNT_W + 1;

   state_t              state;
   logic [addr_width:0] words_total;
   logic [addr_width:0] words_issued;
   logic [RD_LAT:0]     tag;
   logic [CNT_W-1:0]    fifo_count;
   logic [CNT_W-1:0]    inflight;
   logic [SUM_W-1:0]    credit_sum;
   logic                fifo_empty;
   logic                fifo_full;
   logic [DATA_W-1:0]   fifo_head;
   logic                credit_ok;
   logic                issue;
   logic                push;
   logic                pop;
   logic                drain_last;

   // Reads in flight are the set tag bits; together with FIFO occupancy they
   // bound how many words can still land, so a push can never overflow.
   always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i <= RD_LAT; i++)
         inflight = inflight + CNT_W'(tag[i]);
      credit_sum = SUM_W'(fifo_count) + SUM_W'(inflight);
      credit_ok  = !fifo_full && (credit_sum < SUM_W'(FIFO_DEPTH));
   end

   // The first read issues on the accepting start edge; the rest in ISSUE.
   always_comb begin
      issue = 1'b0;
      if (state == IDLE)
         issue = start && (num_words != '0);
      else if (state == ISSUE)
         issue = (words_issued != words_total) && credit_ok;
   end

   assign push      = tag[RD_LAT];
   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;
   assign BRAM2_wr  = 1'b0;

   // Finish once the last buffered word leaves this cycle and nothing is in flight.
   assign drain_last = (tag == '0) &&
                       (fifo_empty || ((fifo_count == CNT_W'(1)) && pop));

   // Sequencer: BRAM2_addr always holds the address of the most recent read.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         BRAM2_addr   <= '0;
         words_total  <= '0;
         words_issued <= '0;
         tag          <= '0;
      end else begin
         tag  <= {tag[RD_LAT-1:0], issue};
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  words_total <= num_words;
                  if (num_words == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state        <= ISSUE;
                     busy         <= 1'b1;
                     BRAM2_addr   <= base_addr;
                     words_issued <= (addr_width+1)'(1);
                  end
               end
            end
            ISSUE: begin
               if (issue) begin
                  BRAM2_addr   <= BRAM2_addr + addr_width'(1);
                  words_issued <= words_issued + (addr_width+1)'(1);
               end else if (words_issued == words_total) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (drain_last) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   skip_rd_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (BRAM2_out),
      .pop       (pop),
      .pop_data  (fifo_head),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   // Output lane conditioning at the FIFO head.
   always_comb begin
      out_data = fifo_head;
`ifdef SKIP_RELU_EN
      for (int unsigned i = 0; i < N_adder_tree; i++)
         out_data[lane_lsb(i) +: LANE_W] = relu_lane(fifo_head[lane_lsb(i) +: LANE_W]);
`else
      // Raw passthrough: lanes leave exactly as read.
`endif
   end

endmodule

// File: tb/tb_skip_mem_reader.sv
// Bench for skip_mem_reader: BRAM model, scoreboard queue filled at command
// time, negedge monitor popping on every accepted word.
module tb_skip_mem_reader;

   localparam int unsigned N   = 4;
   localparam int unsigned AW  = 10;
   localparam int unsigned RL  = 1;
   localparam int unsigned FD  = 4;
   localparam int unsigned DW  = N * 16;
   localparam int unsigned MEM = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   num_words;
   logic          busy;
   logic          done;
   logic [AW-1:0] BRAM2_addr;
   logic          BRAM2_wr;
   logic [DW-1:0] BRAM2_out;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;

   skip_mem_reader #(
      .N_adder_tree (N),
      .addr_width   (AW),
      .RD_LAT       (RL),
      .FIFO_DEPTH   (FD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .num_words  (num_words),
      .busy       (busy),
      .done       (done),
      .BRAM2_addr (BRAM2_addr),
      .BRAM2_wr   (BRAM2_wr),
      .BRAM2_out  (BRAM2_out),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory contents and a BRAM with RL cycles of read latency.
   logic [DW-1:0] tb_mem [MEM];
   logic [DW-1:0] bram_pipe [RL];
   always @(posedge clk) begin
      bram_pipe[0] <= tb_mem[BRAM2_addr];
      for (int i = 1; i < RL; i++) bram_pipe[i] <= bram_pipe[i-1];
   end
   assign BRAM2_out = bram_pipe[RL-1];

   int n_cmp = 0;
   int n_err = 0;
   logic [DW-1:0] exp_q [$];
   int acc_cnt = 0;
   int acc_base = 0;
   int last_acc_cyc = 0;
   int first_valid_cyc = -1;
   int start_cyc = 0;
   bit busy_seen = 0;
   int rdy_mode = 3;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference word: the stored word, lanes clamped when the clamp build is selected.
   function automatic logic [DW-1:0] model_word(input int a);
      logic [DW-1:0] w;
      w = tb_mem[a % MEM];
`ifdef SKIP_RELU_EN
      for (int l = 0; l < N; l++)
         if (w[l*16+15]) w[l*16 +: 16] = 16'h0000;
`endif
      return w;
   endfunction

   // Downstream ready generator (mode 3 = driven by the test sequence).
   initial forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
         0: out_ready = 1'b1;
         1: out_ready = ($urandom_range(0, 3) != 0);
         2: out_ready = 1'b0;
         default: ;
      endcase
   end

   // Monitor: every accepted word is checked against the head of the scoreboard.
   initial begin
      bit stall_prev;
      logic [DW-1:0] stall_data;
      logic [DW-1:0] e;
      stall_prev = 1'b0;
      stall_data = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_prev = 1'b0;
         end else begin
            if (busy) busy_seen = 1'b1;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (stall_prev) begin
               chk("stall_valid", 64'(out_valid), 64'd1);
               chk("stall_data", out_data, stall_data);
            end
            if (out_valid && out_ready) begin
               acc_cnt++;
               last_acc_cyc = cyc;
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_word: got %0h expected none (cycle %0d)", out_data, cyc);
               end else begin
                  e = exp_q.pop_front();
                  chk("word", out_data, e);
               end
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
         end
      end
   end

   task automatic start_xfer(input int b, input int n, input bit push_exp);
      @(posedge clk);
      #1;
      base_addr = AW'(b);
      num_words = (AW+1)'(n);
      start     = 1'b1;
      start_cyc = cyc;
      if (push_exp)
         for (int k = 0; k < n; k++) exp_q.push_back(model_word(b + k));
      first_valid_cyc = -1;
      busy_seen       = 1'b0;
      acc_base        = acc_cnt;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic finish_xfer(input int n, input bit timing);
      bit got;
      int done_at;
      got = 1'b0;
      done_at = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            done_at = cyc;
            break;
         end
      end
      chk("done_seen", 64'(got), 64'd1);
      if (got) begin
         chk("accepted_count", 64'(acc_cnt - acc_base), 64'(n));
         chk("queue_empty", 64'(exp_q.size()), 64'd0);
         if (n == 0) begin
            chk("zero_done_time", 64'(done_at), 64'(start_cyc + 1));
            chk("zero_busy", 64'(busy_seen), 64'd0);
            chk("zero_valid", 64'(first_valid_cyc), 64'(-1));
         end else begin
            chk("done_after_last", 64'(done_at), 64'(last_acc_cyc + 1));
            if (timing) begin
               chk("first_latency", 64'(first_valid_cyc), 64'(start_cyc + RL + 2));
               chk("back_to_back", 64'(last_acc_cyc - first_valid_cyc), 64'(n - 1));
            end
         end
         @(negedge clk);
         chk("done_pulse_end", 64'(done), 64'd0);
         chk("busy_end", 64'(busy), 64'd0);
      end
      exp_q.delete();
   endtask

   initial begin
      logic [AW-1:0] a5;
      logic [DW-1:0] relu_exp;
      int issued;
      bit got;

      for (int k = 0; k < MEM; k++)
         for (int l = 0; l < N; l++)
            tb_mem[k][l*16 +: 16] = 16'(k * 16 + l);
      tb_mem[100] = 64'h7FFF_0001_8000_FFFF;
`ifdef SKIP_RELU_EN
      relu_exp = 64'h7FFF_0001_0000_0000;
`else
      relu_exp = 64'h7FFF_0001_8000_FFFF;
`endif

      rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_addr", 64'(BRAM2_addr), 64'd0);
      chk("rst_wr", 64'(BRAM2_wr), 64'd0);
      rst = 1'b0;

      // Basic read, full throughput.
      rdy_mode = 0; out_ready = 1'b1;
      start_xfer(5, 8, 1);
      finish_xfer(8, 1);

      // Backpressure: alternating ready, then a long stall exhausting credits.
      rdy_mode = 3; out_ready = 1'b1;
      start_xfer(40, 16, 1);
      for (int i = 0; i < 8; i++) begin
         out_ready = (i % 2 == 0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      a5 = BRAM2_addr;
      @(posedge clk);
      #1;
      chk("bp_addr_hold", 64'(BRAM2_addr), 64'(a5));
      issued = ((int'(BRAM2_addr) - 40 + MEM) % MEM) + 1;
      chk("bp_credit", 64'(issued - (acc_cnt - acc_base)), 64'(FD));
      rdy_mode = 0; out_ready = 1'b1;
      finish_xfer(16, 0);

      // Address wrap-around.
      start_xfer(1020, 8, 1);
      finish_xfer(8, 1);

      // Edge counts.
      start_xfer(77, 0, 1);
      finish_xfer(0, 0);
      start_xfer(500, 1, 1);
      finish_xfer(1, 1);

      // Lane clamp word.
      start_xfer(100, 1, 0);
      exp_q.push_back(relu_exp);
      finish_xfer(1, 1);

      // Reset mid-transfer after three accepted words.
      start_xfer(200, 10, 1);
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (acc_cnt - acc_base >= 3) begin
            got = 1'b1;
            break;
         end
      end
      chk("rst_mid_reach3", 64'(got), 64'd1);
      rdy_mode = 3; out_ready = 1'b0; rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_valid", 64'(out_valid), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_addr", 64'(BRAM2_addr), 64'd0);
      rst = 1'b0;
      exp_q.delete();
      got = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (done || out_valid) got = 1'b1;
      end
      chk("abort_quiet", 64'(got), 64'd0);

      // Start pulse during ISSUE is ignored.
      rdy_mode = 1;
      start_xfer(300, 12, 1);
      @(posedge clk);
      #1;
      chk("busy_in_issue", 64'(busy), 64'd1);
      base_addr = AW'(700); num_words = (AW+1)'(5); start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      finish_xfer(12, 0);

      // Randomized transfers under random backpressure.
      for (int r = 0; r < 8; r++) begin
         int b;
         int n;
         b = int'($urandom_range(0, MEM - 1));
         n = int'($urandom_range(1, 24));
         start_xfer(b, n, 1);
         finish_xfer(n, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/skip_mem_reader.md
Name: skip_mem_reader

Overview:
- Read-side sequencer for the banked skip-connection buffer (N_adder_tree lanes x 16 bit, one shared address, wr input).
- On `start`, issues `num_words` consecutive reads from `base_addr` and absorbs the fixed BRAM read latency.
- Streams each word to the residual-add stage over a valid/ready handshake, with no loss or duplication under backpressure.
- Sits between the skip memory and the layer's residual adder.

Parameters:
- N_adder_tree, 16, number of 16-bit lanes per memory word.
- addr_width, 10, address width of the skip memory.
- RD_LAT, 1, cycles from address presentation to valid BRAM2_out (1..3).
- FIFO_DEPTH, 4, output buffer depth; must be >= RD_LAT+2, power of two.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle pulse; sampled only in IDLE.
- base_addr, input, addr_width, first read address; latched on accepted start.
- num_words, input, addr_width+1, words to read; latched on accepted start.
- busy, output, 1, high from the cycle after an accepted start until `done`.
- done, output, 1, one-cycle pulse after the last word is accepted downstream.
- BRAM2_addr, output, addr_width, read address to the skip memory.
- BRAM2_wr, output, 1, memory write enable; tied 0.
- BRAM2_out, input, N_adder_tree*16, read data from the skip memory.
- out_data, output, N_adder_tree*16, word to the residual adder; lane i at bits [(i+1)*16-1:i*16].
- out_valid, output, 1, out_data valid.
- out_ready, input, 1, downstream accept.

Behaviour:
- Reset values: busy=0, done=0, out_valid=0, BRAM2_addr=0, BRAM2_wr=0; FIFO emptied; in-flight reads discarded. Reset mid-operation aborts with no done pulse.
- States:
  - IDLE: start → ISSUE (IDLE → DONE if num_words==0).
  - ISSUE: issue count reaches num_words → DRAIN.
  - DRAIN: FIFO empty and no reads in flight → DONE.
  - DONE: done=1 for one cycle → IDLE.
- A start pulse outside IDLE is ignored.
- Issue rule, per cycle in ISSUE:
  - A read issues when fifo_count + inflight < FIFO_DEPTH (credit check).
  - BRAM2_addr is registered and increments by 1 per issued read, wrapping modulo 2^addr_width (1023+1 → 0).
  - A delay line of RD_LAT+1 valid bits tags each issued read. When a tag emerges, BRAM2_out is pushed into the FIFO. The credit check guarantees the push never overflows.
- Output:
  - out_valid = FIFO non-empty; out_data = FIFO head.
  - A pop occurs when out_valid && out_ready.
  - out_data is held stable while out_valid && !out_ready.
- Latency: first out_valid appears RD_LAT+2 cycles after start.
- Throughput: 1 word/cycle sustained with out_ready held high.
- Simultaneous push and pop in the same cycle: count unchanged; both take effect.
- Lanes are passed through unaltered; no width change.

Optional Feature:
- Macro: SKIP_RELU_EN.
- Defined: each 16-bit lane is treated as signed two's complement and clamped to 0 if negative, applied combinationally at the FIFO output. Lane 0x8000 → 0x0000; 0x7FFF unchanged.
- Undefined: raw passthrough.
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package `skip_mem_pkg`:
  - LANE_W=16 constant.
  - Lane-slice helper function.
  - State enum {IDLE, ISSUE, DRAIN, DONE}.
- Sub-module `skip_rd_fifo`: synchronous FIFO, parameterised on width and depth, exposing count/empty/full. It holds the buffer; the sequencer owns the FSM, credit check and latency tag line.

Test Plan:
- Basic read: memory word k filled with lane value k*16+lane; base 5, num_words 8, out_ready=1 → 8 words for addresses 5..12 in order, back to back, first word at cycle RD_LAT+2, done one cycle after the last accept.
- Backpressure: out_ready toggles 1010…, then held low 6 cycles → no word dropped or duplicated; out_data stable while stalled; BRAM2_addr stops advancing once FIFO_DEPTH credits are consumed.
- Wrap-around: base 1020, num_words 8 → addresses 1020..1023, 0..3 delivered in order.
- Edge counts: num_words 0 → done pulse, zero out_valid, busy never asserted; num_words 1 → exactly one word, then done.
- Reset and ignored start: rst asserted after 3 of 10 words accepted → next cycle out_valid=0, busy=0, no done; a start pulse during ISSUE is ignored and the original transfer completes unaffected.
- With SKIP_RELU_EN: lanes 0xFFFF, 0x8000, 0x0001, 0x7FFF → 0x0000, 0x0000, 0x0001, 0x7FFF. Same stimulus without the macro → unchanged values.
